mips_multicycle_ctrl: RTL and testbench

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

---
 rtl/mips_ctrl_pkg.sv | 56 +++++
 rtl/mips_main_decoder.sv | 32 +++
 rtl/mips_multicycle_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - state, opcode and control-field encodings for the multicycle controller (MIPS_JUMP_EN adds JUMP)
package mips_ctrl_pkg;

  // Controller states; JUMP only exists when the jump feature is built in
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10
`ifdef MIPS_JUMP_EN
    , S_JUMP = 4'd11
`endif
  } state_t;

  // Opcode field values, instcode[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Instruction classes produced by the main decoder
  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_MEM     = 3'd1,
    CLS_BEQ     = 3'd2,
    CLS_ADDI    = 3'd3,
    CLS_JUMP    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_t;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_main_decoder.sv
// rtl/mips_main_decoder.sv - combinational opcode classifier (MIPS_JUMP_EN enables J decode)
module mips_main_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class,
  output logic       is_store
);

  // Map the opcode onto an instruction class; anything unknown is illegal
  always_comb begin
    op_class = CLS_ILLEGAL;
    is_store = 1'b0;
    case (opcode)
      OP_RTYPE: op_class = CLS_RTYPE;
      OP_LW:    op_class = CLS_MEM;
      OP_SW: begin
        op_class = CLS_MEM;
        is_store = 1'b1;
      end
      OP_BEQ:   op_class = CLS_BEQ;
      OP_ADDI:  op_class = CLS_ADDI;
`ifdef MIPS_JUMP_EN
      OP_J:     op_class = CLS_JUMP;
`else
      OP_J:     op_class = CLS_ILLEGAL;
`endif
      default:  op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with retirement counter (MIPS_JUMP_EN adds JUMP)
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instcode,
  input  logic        zero,
  input  logic        memReady,
  output logic        pcWrite,
  output logic        irWrite,
  output logic        iorD,
  output logic        memRead,
  output logic        memWrite,
  output logic        regWrite,
  output logic        regDst,
  output logic        memtoReg,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  ALUcontrol,
  output logic [1:0]  pcSource,
  output logic        illegalOp,
  output logic [31:0] instrRetired
);

  state_t      state;
  state_t      next_state;
  op_class_t   op_class;
  logic        is_store;
  logic        retire;
  logic [31:0] retired_cnt;

  logic pc_write_raw;
  logic ir_write_raw;
  logic mem_read_raw;
  logic mem_write_raw;
  logic reg_write_raw;

  // Only the opcode steers the controller; the rest of the IR feeds the datapath
  logic unused_instcode;
  assign unused_instcode = ^instcode[25:0];

  mips_main_decoder u_decoder (
    .opcode   (instcode[31:26]),
    .op_class (op_class),
    .is_store (is_store)
  );

  // State register; reset always returns to FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; memory states wait on memReady, others ignore it
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (memReady) next_state = S_DECODE;
      S_DECODE: begin
        case (op_class)
          CLS_RTYPE: next_state = S_EXEC;
          CLS_MEM:   next_state = S_MEMADR;
          CLS_BEQ:   next_state = S_BRANCH;
          CLS_ADDI:  next_state = S_ADDIEX;
`ifdef MIPS_JUMP_EN
          CLS_JUMP:  next_state = S_JUMP;
`endif
          default:   next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (memReady) next_state = S_MEMWB;
      S_MEMWR:  if (memReady) next_state = S_FETCH;
      S_MEMWB:  next_state = S_FETCH;
      S_EXEC:   next_state = S_ALUWB;
      S_ALUWB:  next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_ADDIEX: next_state = S_ADDIWB;
      S_ADDIWB: next_state = S_FETCH;
`ifdef MIPS_JUMP_EN
      S_JUMP:   next_state = S_FETCH;
`endif
      default:  next_state = S_FETCH;
    endcase
  end

  // Moore outputs per state; only the FETCH/BRANCH PC strobes look at inputs
  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    iorD          = 1'b0;
    regDst        = 1'b0;
    memtoReg      = 1'b0;
    aluSrcA       = 1'b0;
    aluSrcB       = SRCB_REGB;
    ALUcontrol    = ALU_ADD;
    pcSource      = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        aluSrcB      = SRCB_FOUR;
        ir_write_raw = memReady;
        pc_write_raw = memReady;
      end
      S_DECODE: aluSrcB = SRCB_IMMSH;
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read_raw = 1'b1;
        iorD         = 1'b1;
      end
      S_MEMWR: begin
        mem_write_raw = 1'b1;
        iorD          = 1'b1;
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        memtoReg      = 1'b1;
      end
      S_EXEC: begin
        aluSrcA    = 1'b1;
        ALUcontrol = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        regDst        = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA      = 1'b1;
        ALUcontrol   = ALU_SUB;
        pcSource     = PCSRC_ALUOUT;
        pc_write_raw = zero;
      end
      S_ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      S_ADDIWB: reg_write_raw = 1'b1;
`ifdef MIPS_JUMP_EN
      S_JUMP: begin
        pcSource     = PCSRC_JUMP;
        pc_write_raw = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Strobes are held off for as long as reset is asserted
  assign pcWrite  = pc_write_raw  & ~rst;
  assign irWrite  = ir_write_raw  & ~rst;
  assign memRead  = mem_read_raw  & ~rst;
  assign memWrite = mem_write_raw & ~rst;
  assign regWrite = reg_write_raw & ~rst;

  // An instruction retires on the edge that leaves its last state for FETCH
  always_comb begin
    retire = 1'b0;
    case (state)
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB: retire = 1'b1;
      S_MEMWR: retire = memReady;
`ifdef MIPS_JUMP_EN
      S_JUMP:  retire = 1'b1;
`endif
      default: retire = 1'b0;
    endcase
  end

  // Retirement counter, wraps naturally at 32 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= 32'd0;
    end else if (retire) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end

  assign instrRetired = retired_cnt;

  // Illegal-opcode flag is registered so it shows for the single FETCH cycle after DECODE
  always_ff @(posedge clk) begin
    if (rst) begin
      illegalOp <= 1'b0;
    end else begin
      illegalOp <= (state == S_DECODE) && (op_class == CLS_ILLEGAL);
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for the multicycle controller (MIPS_JUMP_EN selects J expectations)
module tb_mips_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instcode;
  logic        zero;
  logic        memReady;
  logic        pcWrite, irWrite, iorD, memRead, memWrite;
  logic        regWrite, regDst, memtoReg, aluSrcA;
  logic [1:0]  aluSrcB, ALUcontrol, pcSource;
  logic        illegalOp;
  logic [31:0] instrRetired;

  mips_multicycle_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .instcode     (instcode),
    .zero         (zero),
    .memReady     (memReady),
    .pcWrite      (pcWrite),
    .irWrite      (irWrite),
    .iorD         (iorD),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .regWrite     (regWrite),
    .regDst       (regDst),
    .memtoReg     (memtoReg),
    .aluSrcA      (aluSrcA),
    .aluSrcB      (aluSrcB),
    .ALUcontrol   (ALUcontrol),
    .pcSource     (pcSource),
    .illegalOp    (illegalOp),
    .instrRetired (instrRetired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [14:0] ctrl;
  assign ctrl = {pcWrite, irWrite, iorD, memRead, memWrite, regWrite, regDst,
                 memtoReg, aluSrcA, aluSrcB, ALUcontrol, pcSource};

  typedef struct {
    logic        r;
    logic        mr;
    logic        z;
    logic [31:0] ins;
  } stim_t;

  typedef struct {
    logic [14:0] ctrl;
    logic        ill;
    logic [31:0] ret;
    string       tag;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    checks;
  int    errors;
  logic [31:0] exp_ret;

  localparam logic [31:0] I_LW   = 32'h8C480004;
  localparam logic [31:0] I_SW   = 32'hAC480008;
  localparam logic [31:0] I_R    = 32'h012A4020;
  localparam logic [31:0] I_BEQ  = 32'h11090003;
  localparam logic [31:0] I_ADDI = 32'h21080005;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_BAD  = 32'hFC000000;

  logic [14:0] v_rst, v_fw, v_fr, v_dec, v_madr, v_mrd, v_mrd_rst, v_mwb, v_mwr;
  logic [14:0] v_exec, v_aluwb, v_br1, v_br0, v_aex, v_awb, v_jmp;

  function automatic logic [14:0] mk(input logic pcw, input logic irw, input logic iord,
                                     input logic mr, input logic mw, input logic rw,
                                     input logic rd, input logic m2r, input logic asa,
                                     input logic [1:0] asb, input logic [1:0] aluc,
                                     input logic [1:0] pcs);
    return {pcw, irw, iord, mr, mw, rw, rd, m2r, asa, asb, aluc, pcs};
  endfunction

  // Queue one cycle of stimulus together with the outputs expected in that cycle
  task automatic add(input logic r, input logic mr, input logic z, input logic [31:0] ins,
                     input logic [14:0] c, input logic ill, input string tag);
    stim_t s;
    exp_t  e;
    s.r = r; s.mr = mr; s.z = z; s.ins = ins;
    e.ctrl = c; e.ill = ill; e.ret = exp_ret; e.tag = tag;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    stim_t s;
    exp_t  e;
    add(1, 0, 0, 32'h0, v_rst, 0, "reset_idle");
    add(1, 1, 0, I_LW,  v_rst, 0, "reset_strobes_masked");
    add(0, 0, 0, 32'h0, v_fw,  0, "reset_release_fetch");
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      rst = s.r; memReady = s.mr; zero = s.z; instcode = s.ins;
      #1;
      checks++;
      if ({ctrl, illegalOp, instrRetired} !== {e.ctrl, e.ill, e.ret}) begin
        errors++;
        $display("FAIL %s: got ctrl=%b ill=%b ret=%h want ctrl=%b ill=%b ret=%h",
                 e.tag, ctrl, illegalOp, instrRetired, e.ctrl, e.ill, e.ret);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    stim_t s;
    exp_t  e;
    add(0, 0, 0, I_LW, v_fw,   0, "lw_fetch_wait");
    add(0, 1, 0, I_LW, v_fr,   0, "lw_fetch_ready");
    add(0, 0, 0, I_LW, v_dec,  0, "lw_decode");
    add(0, 1, 0, I_LW, v_madr, 0, "lw_memadr");
    for (int i = 0; i < 3; i++) add(0, 0, 0, I_LW, v_mrd, 0, "lw_memrd_wait");
    add(0, 1, 0, I_LW, v_mrd,  0, "lw_memrd_ready");
    add(0, 0, 0, I_LW, v_mwb,  0, "lw_memwb");
    exp_ret++;
    add(0, 0, 0, I_LW, v_fw,   0, "lw_retired");
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      rst = s.r; memReady = s.mr; zero = s.z; instcode = s.ins;
      #1;
      checks++;
      if ({ctrl, illegalOp, instrRetired} !== {e.ctrl, e.ill, e.ret}) begin
        errors++;
        $display("FAIL %s: got ctrl=%b ill=%b ret=%h want ctrl=%b ill=%b ret=%h",
                 e.tag, ctrl, illegalOp, instrRetired, e.ctrl, e.ill, e.ret);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_r_beq();
    stim_t s;
    exp_t  e;
    add(0, 1, 0, I_SW, v_fr,   0, "sw_fetch");
    add(0, 0, 0, I_SW, v_dec,  0, "sw_decode");
    add(0, 0, 0, I_SW, v_madr, 0, "sw_memadr");
    add(0, 0, 0, I_SW, v_mwr,  0, "sw_memwr_wait");
    add(0, 1, 0, I_SW, v_mwr,  0, "sw_memwr_ready");
    exp_ret++;
    add(0, 1, 0, I_R,  v_fr,    0, "r_fetch");
    add(0, 1, 0, I_R,  v_dec,   0, "r_decode");
    add(0, 1, 0, I_R,  v_exec,  0, "r_exec");
    add(0, 1, 0, I_R,  v_aluwb, 0, "r_aluwb");
    exp_ret++;
    add(0, 1, 0, I_BEQ, v_fr,  0, "beq1_fetch");
    add(0, 0, 1, I_BEQ, v_dec, 0, "beq1_decode");
    add(0, 0, 1, I_BEQ, v_br1, 0, "beq_taken");
    exp_ret++;
    add(0, 1, 0, I_BEQ, v_fr,  0, "beq0_fetch");
    add(0, 0, 0, I_BEQ, v_dec, 0, "beq0_decode");
    add(0, 0, 0, I_BEQ, v_br0, 0, "beq_not_taken");
    exp_ret++;
    add(0, 0, 0, I_BEQ, v_fw,  0, "beq_retired");
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      rst = s.r; memReady = s.mr; zero = s.z; instcode = s.ins;
      #1;
      checks++;
      if ({ctrl, illegalOp, instrRetired} !== {e.ctrl, e.ill, e.ret}) begin
        errors++;
        $display("FAIL %s: got ctrl=%b ill=%b ret=%h want ctrl=%b ill=%b ret=%h",
                 e.tag, ctrl, illegalOp, instrRetired, e.ctrl, e.ill, e.ret);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_jump();
    stim_t s;
    exp_t  e;
    add(0, 1, 0, I_BAD, v_fr,  0, "bad_fetch");
    add(0, 1, 0, I_BAD, v_dec, 0, "bad_decode");
    add(0, 0, 0, I_BAD, v_fw,  1, "bad_illegal_pulse");
    add(0, 0, 0, I_BAD, v_fw,  0, "bad_pulse_cleared");
    add(0, 1, 0, I_J,   v_fr,  0, "j_fetch");
    add(0, 0, 0, I_J,   v_dec, 0, "j_decode");
`ifdef MIPS_JUMP_EN
    add(0, 0, 0, I_J,   v_jmp, 0, "j_jump");
    exp_ret++;
    add(0, 0, 0, I_J,   v_fw,  0, "j_retired");
`else
    add(0, 0, 0, I_J,   v_fw,  1, "j_illegal_pulse");
    add(0, 0, 0, I_J,   v_fw,  0, "j_pulse_cleared");
`endif
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      rst = s.r; memReady = s.mr; zero = s.z; instcode = s.ins;
      #1;
      checks++;
      if ({ctrl, illegalOp, instrRetired} !== {e.ctrl, e.ill, e.ret}) begin
        errors++;
        $display("FAIL %s: got ctrl=%b ill=%b ret=%h want ctrl=%b ill=%b ret=%h",
                 e.tag, ctrl, illegalOp, instrRetired, e.ctrl, e.ill, e.ret);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    stim_t s;
    exp_t  e;
    add(0, 1, 0, I_R,  v_fr,   0, "rmid_fetch");
    add(0, 0, 0, I_R,  v_dec,  0, "rmid_decode");
    add(1, 0, 0, I_R,  v_exec, 0, "rmid_exec_rst");
    exp_ret = 32'd0;
    add(0, 0, 0, I_R,  v_fw,   0, "rmid_back_to_fetch");
    add(0, 1, 0, I_ADDI, v_fr,  0, "addi_fetch");
    add(0, 0, 0, I_ADDI, v_dec, 0, "addi_decode");
    add(0, 0, 0, I_ADDI, v_aex, 0, "addi_ex");
    add(0, 0, 0, I_ADDI, v_awb, 0, "addi_wb");
    exp_ret++;
    add(0, 1, 0, I_LW, v_fr,      0, "wrst_fetch");
    add(0, 0, 0, I_LW, v_dec,     0, "wrst_decode");
    add(0, 0, 0, I_LW, v_madr,    0, "wrst_memadr");
    add(0, 0, 0, I_LW, v_mrd,     0, "wrst_memrd_wait");
    add(1, 1, 0, I_LW, v_mrd_rst, 0, "wrst_memrd_rst");
    exp_ret = 32'd0;
    add(0, 0, 0, I_LW, v_fw,      0, "wrst_back_to_fetch");
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      rst = s.r; memReady = s.mr; zero = s.z; instcode = s.ins;
      #1;
      checks++;
      if ({ctrl, illegalOp, instrRetired} !== {e.ctrl, e.ill, e.ret}) begin
        errors++;
        $display("FAIL %s: got ctrl=%b ill=%b ret=%h want ctrl=%b ill=%b ret=%h",
                 e.tag, ctrl, illegalOp, instrRetired, e.ctrl, e.ill, e.ret);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    stim_t s;
    exp_t  e;
    memReady = 1'b0;
    force dut.retired_cnt = 32'hFFFFFFFE;
    #1;
    release dut.retired_cnt;
    exp_ret = 32'hFFFFFFFE;
    add(0, 0, 0, I_ADDI, v_fw, 0, "wrap_preload");
    for (int i = 0; i < 2; i++) begin
      add(0, 1, 0, I_ADDI, v_fr,  0, "wrap_fetch");
      add(0, 0, 0, I_ADDI, v_dec, 0, "wrap_decode");
      add(0, 0, 0, I_ADDI, v_aex, 0, "wrap_addiex");
      add(0, 0, 0, I_ADDI, v_awb, 0, "wrap_addiwb");
      exp_ret++;
    end
    add(0, 0, 0, I_ADDI, v_fw, 0, "wrap_to_zero");
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      rst = s.r; memReady = s.mr; zero = s.z; instcode = s.ins;
      #1;
      checks++;
      if ({ctrl, illegalOp, instrRetired} !== {e.ctrl, e.ill, e.ret}) begin
        errors++;
        $display("FAIL %s: got ctrl=%b ill=%b ret=%h want ctrl=%b ill=%b ret=%h",
                 e.tag, ctrl, illegalOp, instrRetired, e.ctrl, e.ill, e.ret);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    //           pcw irw iord mr mw rw rd m2r asa asb    aluc   pcs
    v_rst     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
    v_fw      = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
    v_fr      = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
    v_dec     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
    v_madr    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
    v_mrd     = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    v_mrd_rst = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    v_mwb     = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00);
    v_mwr     = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    v_exec    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00);
    v_aluwb   = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00);
    v_br1     = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
    v_br0     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
    v_aex     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
    v_awb     = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    v_jmp     = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10);
    checks   = 0;
    errors   = 0;
    exp_ret  = 32'd0;
    rst      = 1'b1;
    memReady = 1'b0;
    zero     = 1'b0;
    instcode = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_lw_wait();
    test_sw_r_beq();
    test_illegal_jump();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
